// File: rtl/sd_dat_rx_if.sv
// sd_dat_rx_if: strobe/data/control inputs and byte/status outputs of the SD DAT0 block receiver.
interface sd_dat_rx_if;
    logic       sample_en;
    logic       dat_in;
    logic       rx_start;
    logic       abort;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;
    logic       done;
    logic       crc_err;
    logic       end_err;
    logic       timeout;
    modport master (
        output sample_en, dat_in, rx_start, abort,
        input  byte_out, byte_valid, busy, done, crc_err, end_err, timeout
    );
    modport slave (
        input  sample_en, dat_in, rx_start, abort,
        output byte_out, byte_valid, busy, done, crc_err, end_err, timeout
    );
endinterface

// File: rtl/sd_dat_rx.sv
// sd_dat_rx: SD DAT0 single-block receiver; shifts bytes in MSB-first, then checks CRC16-CCITT and end bit.
module sd_dat_rx #(
    parameter int BLOCK_BYTES     = 512,
    parameter int TIMEOUT_STROBES = 1024
) (
    input logic        clk,
    input logic        rst,
    sd_dat_rx_if.slave rx_if
);
    localparam int BW = $clog2(BLOCK_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_STROBES + 1);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, ENDBIT, DONE} state_t;
    state_t        state_q;
    logic [7:0]    sh_q, byte_q, sh_d;
    logic [2:0]    bit_q;
    logic [3:0]    ccnt_q;
    logic [BW-1:0] bcnt_q;
    logic [TW-1:0] tcnt_q;
    logic [15:0]   crc_q, rx_crc_q, crc_d;
    logic          valid_q, crc_err_q, end_err_q, timeout_q, fb;
    assign sh_d  = {sh_q[6:0], rx_if.dat_in};
    assign fb    = crc_q[15] ^ rx_if.dat_in;
    assign crc_d = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            ccnt_q    <= '0;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (rx_if.abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (rx_if.rx_start) begin
                    state_q   <= WAIT_START;
                    crc_err_q <= 1'b0;
                    end_err_q <= 1'b0;
                    timeout_q <= 1'b0;
                    crc_q     <= '0;
                    rx_crc_q  <= '0;
                    bit_q     <= '0;
                    bcnt_q    <= '0;
                    tcnt_q    <= '0;
                    ccnt_q    <= '0;
                end
                WAIT_START: if (rx_if.sample_en) begin
                    if (!rx_if.dat_in) begin
                        state_q <= DATA;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (tcnt_q == TW'(TIMEOUT_STROBES - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                DATA: if (rx_if.sample_en) begin
                    sh_q  <= sh_d;
                    crc_q <= crc_d;
                    bit_q <= bit_q + 1'b1;
                    // byte_out is loaded on the 8th-bit edge so byte_valid shows in the following cycle
                    if (bit_q == 3'd7) begin
                        byte_q  <= sh_d;
                        valid_q <= 1'b1;
                        bcnt_q  <= bcnt_q + 1'b1;
                        if (bcnt_q == BW'(BLOCK_BYTES - 1)) state_q <= CRC;
                    end
                end
                CRC: if (rx_if.sample_en) begin
                    rx_crc_q <= {rx_crc_q[14:0], rx_if.dat_in};
                    ccnt_q   <= ccnt_q + 1'b1;
                    if (ccnt_q == 4'd15) state_q <= ENDBIT;
                end
                ENDBIT: if (rx_if.sample_en) begin
                    end_err_q <= !rx_if.dat_in;
                    crc_err_q <= rx_crc_q != crc_q;
                    state_q   <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rx_if.byte_out   = byte_q;
    assign rx_if.byte_valid = valid_q;
    assign rx_if.busy       = !(state_q == IDLE || state_q == DONE);
    assign rx_if.done       = state_q == DONE;
    assign rx_if.crc_err    = crc_err_q;
    assign rx_if.end_err    = end_err_q;
    assign rx_if.timeout    = timeout_q;
endmodule

// File: tb/tb_sd_dat_rx.sv
// tb_sd_dat_rx: vector table of "123456789" blocks plus timeout, abort and reset sequences;
// expected bytes are queued as they are driven and popped when byte_valid appears.
module tb_sd_dat_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0, done_cnt = 0, bv_cnt = 0;
    logic [7:0] exp_q[$];
    typedef struct packed {
        logic [15:0] crc;
        logic        endb;
        logic        gap;
        logic        mid;
        logic        exp_crc;
        logic        exp_end;
    } vec_t;

    sd_dat_rx_if rx();
    sd_dat_rx #(.BLOCK_BYTES(9), .TIMEOUT_STROBES(16)) dut (.clk(clk), .rst(rst), .rx_if(rx));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {18'h0, rx.byte_out, rx.byte_valid, rx.busy, rx.done,
                     rx.crc_err, rx.end_err, rx.timeout}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (rx.done === 1'b1) done_cnt++;
        if (rx.byte_valid === 1'b1) begin
            bv_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected byte_valid: byte_out=%h with nothing expected", rx.byte_out);
            end else begin
                check("byte_out", 32'(rx.byte_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap cycles drive the inverted bit with sample_en low so ignored cycles carry wrong data
    task automatic strobe(input logic b, input int gap);
        repeat (gap) begin
            rx.sample_en = 1'b0;
            rx.dat_in = ~b;
            tick();
        end
        rx.sample_en = 1'b1;
        rx.dat_in = b;
        tick();
        rx.sample_en = 1'b0;
        rx.dat_in = 1'b1;
    endtask

    task automatic arm();
        rx.rx_start = 1'b1;
        tick();
        rx.rx_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) strobe(b[i], gap);
    endtask

    task automatic send_block(input logic [15:0] crc, input logic endb, input logic gapped, input logic mid);
        logic [7:0] d;
        repeat (3) strobe(1'b1, 0);
        strobe(1'b0, 0);
        for (int k = 0; k < 9; k++) begin
            d = 8'h31 + 8'(k);
            exp_q.push_back(d);
            if (mid && k == 3) rx.rx_start = 1'b1;
            send_byte(d, (gapped && k < 5) ? 2 : 0);
            rx.rx_start = 1'b0;
        end
        for (int i = 15; i >= 0; i--) strobe(crc[i], 0);
        strobe(endb, 0);
    endtask

    initial begin
        vec_t v[4];
        int d0, b0;
        logic [7:0] t;
        v[0] = '{16'h31C3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1] = '{16'h31C2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        v[2] = '{16'h31C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        v[3] = '{16'h31C3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rx.sample_en = 1'b0;
        rx.dat_in = 1'b1;
        rx.rx_start = 1'b0;
        rx.abort = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check_zero("reset outputs");

        foreach (v[n]) begin
            d0 = done_cnt;
            b0 = bv_cnt;
            arm();
            check("busy after arm", 32'(rx.busy), 32'd1);
            send_block(v[n].crc, v[n].endb, v[n].gap, v[n].mid);
            repeat (3) tick();
            check("done pulses", 32'(done_cnt - d0), 32'd1);
            check("byte_valid pulses", 32'(bv_cnt - b0), 32'd9);
            check("crc_err", 32'(rx.crc_err), 32'(v[n].exp_crc));
            check("end_err", 32'(rx.end_err), 32'(v[n].exp_end));
            check("timeout", 32'(rx.timeout), 32'd0);
            check("busy after done", 32'(rx.busy), 32'd0);
        end

        d0 = done_cnt;
        b0 = bv_cnt;
        arm();
        repeat (15) strobe(1'b1, 0);
        check("no early timeout done", 32'(rx.done), 32'd0);
        check("busy waiting start", 32'(rx.busy), 32'd1);
        strobe(1'b1, 0);
        check("done after 16th strobe", 32'(rx.done), 32'd1);
        check("timeout flag", 32'(rx.timeout), 32'd1);
        repeat (3) tick();
        check("timeout done pulses", 32'(done_cnt - d0), 32'd1);
        check("timeout byte_valid", 32'(bv_cnt - b0), 32'd0);
        check("timeout sticky", 32'(rx.timeout), 32'd1);

        d0 = done_cnt;
        b0 = bv_cnt;
        arm();
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'h31 + 8'(k));
            send_byte(8'h31 + 8'(k), 0);
        end
        rx.abort = 1'b1;
        tick();
        rx.abort = 1'b0;
        check("busy after abort", 32'(rx.busy), 32'd0);
        for (int k = 0; k < 4; k++) send_byte(8'hA5, 0);
        rx.abort = 1'b1;
        rx.rx_start = 1'b1;
        tick();
        rx.abort = 1'b0;
        rx.rx_start = 1'b0;
        check("abort beats rx_start", 32'(rx.busy), 32'd0);
        arm();
        send_block(16'h31C3, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("abort+block byte_valid", 32'(bv_cnt - b0), 32'd13);
        check("abort+block done", 32'(done_cnt - d0), 32'd1);
        check("abort+block flags", {29'h0, rx.crc_err, rx.end_err, rx.timeout}, 32'd0);

        arm();
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        exp_q.push_back(8'h31);
        send_byte(8'h31, 0);
        t = 8'h32;
        for (int i = 7; i >= 1; i--) strobe(t[i], 0);
        rx.sample_en = 1'b1;
        rx.dat_in = t[0];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx.sample_en = 1'b0;
        check_zero("rst mid-block");
        repeat (3) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
